// File: rtl/approx_mult_seq_ctrl.sv
// rtl/approx_mult_seq_ctrl.sv - sequential shift-add multiplier with optional approximate low adder cells
//
// Purpose:
//   Takes one unsigned operand pair per transaction and walks the multiplier
//   one bit per cycle. Each set bit adds the shifted multiplicand into a
//   2*WIDTH accumulator. When approx_mode is set at accept, the low
//   APPROX_LSBS adder cells are approximate: their carry is kept and their sum
//   is forced to ~carry. The block also drives clock-gate enables so the
//   accumulator and operand registers toggle only when they need to.
//
// Configuration:
//   ZERO_SKIP_EN - when defined, CALC also ends on the edge where the shifted
//                  multiplier becomes zero. Results are unchanged; only the
//                  latency drops.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start_valid  in   request valid
//   start_ready  out  high only in IDLE
//   a            in   multiplicand, sampled at accept
//   b            in   multiplier, sampled at accept
//   approx_mode  in   1 = approximate low cells, sampled at accept
//   result       out  accumulator value, final product while result_valid
//   result_valid out  high in DONE
//   result_ready in   consumer handshake that leaves DONE
//   busy         out  state != IDLE
//   cg_en_acc    out  accumulator clock-gate enable
//   cg_en_op     out  operand/count register clock-gate enable

module approx_mult_seq_ctrl #(
  parameter int WIDTH       = 8,
  parameter int APPROX_LSBS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 approx_mode,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 cg_en_acc,
  output logic                 cg_en_op
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 mode_q, mode_d;

  logic                 accept;
  logic                 last_step;
  logic [WIDTH-1:0]     mplier_shift;
  logic [2*WIDTH-1:0]   add_sum;

  // Ripple adder; carry-out of the MSB is dropped. Approximate cells keep the
  // exact carry chain so the error stays confined to the low sum bits.
  function automatic logic [2*WIDTH-1:0] add_cells(
    input logic [2*WIDTH-1:0] x,
    input logic [2*WIDTH-1:0] y,
    input logic               approx
  );
    logic [2*WIDTH-1:0] s;
    logic               c;
    logic               co;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 2*WIDTH; i++) begin
      co = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      if (approx && (i < APPROX_LSBS)) begin
        s[i] = ~co;
      end else begin
        s[i] = x[i] ^ y[i] ^ c;
      end
      c = co;
    end
    return s;
  endfunction

  // mcand_q holds the multiplicand already shifted by count, so the adder
  // operand is always mcand_q directly.
  assign add_sum      = add_cells(acc_q, mcand_q, mode_q);
  assign accept       = start_valid & (state_q == IDLE);
  assign mplier_shift = mplier_q >> 1;

`ifdef ZERO_SKIP_EN
  assign last_step = (count_q == LAST_CNT) | (mplier_shift == '0);
`else
  assign last_step = (count_q == LAST_CNT);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = CALC;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          count_d  = '0;
          mode_d   = approx_mode;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          acc_d = add_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        count_d  = count_q + CNT_W'(1);
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = acc_q;
  assign cg_en_acc    = (state_q == CALC) & mplier_q[0];
  assign cg_en_op     = accept | (state_q == CALC);

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// tb/tb_approx_mult_seq_ctrl.sv - directed self-checking bench for approx_mult_seq_ctrl

module tb_approx_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        approx_mode;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        cg_en_acc;
  logic        cg_en_op;

  int          n_checks;
  int          n_fail;
  int          lat;
  logic [7:0]  cg_mask;

  approx_mult_seq_ctrl #(.WIDTH(8), .APPROX_LSBS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .approx_mode  (approx_mode),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .cg_en_acc    (cg_en_acc),
    .cg_en_op     (cg_en_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at the falling edge, let the rising edge accept it,
  // then withdraw the request 1 ns later.
  task automatic do_accept(input logic [7:0] av, input logic [7:0] bv, input logic m);
    @(negedge clk);
    start_valid = 1'b1;
    a           = av;
    b           = bv;
    approx_mode = m;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a           = 8'hxx;
    b           = 8'hxx;
    approx_mode = 1'bx;
  endtask

  // Counts rising edges until result_valid, recording cg_en_acc per CALC cycle.
  task automatic wait_done();
    lat     = 0;
    cg_mask = '0;
    while (lat < 40) begin
      if (busy && !result_valid && lat < 8) cg_mask[lat] = cg_en_acc;
      @(posedge clk);
      #1;
      lat++;
      if (result_valid) break;
    end
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    a            = '0;
    b            = '0;
    approx_mode  = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: start_ready=%b busy=%b result_valid=%b, required 1 0 0", start_ready, busy, result_valid);
    end
    n_checks++;
    if (result !== 16'd0 || cg_en_acc !== 1'b0 || cg_en_op !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: result=%0d cg_acc=%b cg_op=%b, required 0 0 0", result, cg_en_acc, cg_en_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact_basic();
    int exp_lat;
`ifdef ZERO_SKIP_EN
    exp_lat = 4;
`else
    exp_lat = 8;
`endif
    @(negedge clk);
    start_valid = 1'b1;
    a = 8'd13;
    b = 8'd11;
    approx_mode = 1'b0;
    #1;
    n_checks++;
    if (cg_en_op !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_cg_op: cg_en_op=%b, required 1", cg_en_op);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL calc_entry: busy=%b start_ready=%b, required 1 0", busy, start_ready);
    end
    wait_done();
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL exact_latency: got %0d cycles, required %0d", lat, exp_lat);
    end
    n_checks++;
    if (result !== 16'd143 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL exact_13x11: result=%0d valid=%b, required 143 1", result, result_valid);
    end
    release_result();
  endtask

  task automatic test_exact_max();
    do_accept(8'd255, 8'd255, 1'b0);
    wait_done();
    n_checks++;
    if (lat !== 8 || result !== 16'd65025) begin
      n_fail++;
      $display("FAIL exact_255x255: result=%0d lat=%0d, required 65025 8", result, lat);
    end
    n_checks++;
    if (cg_mask !== 8'hFF) begin
      n_fail++;
      $display("FAIL cg_acc_all: mask=%b, required 11111111", cg_mask);
    end
    release_result();
  endtask

  task automatic test_approx();
    do_accept(8'd3, 8'd3, 1'b1);
    n_checks++;
    if (cg_en_acc !== 1'b1) begin
      n_fail++;
      $display("FAIL approx_cg_k0: cg_en_acc=%b, required 1", cg_en_acc);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'd15) begin
      n_fail++;
      $display("FAIL approx_k0: acc=%0d, required 15", result);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'd17) begin
      n_fail++;
      $display("FAIL approx_k1: acc=%0d, required 17", result);
    end
    n_checks++;
    if (!result_valid && cg_en_acc !== 1'b0) begin
      n_fail++;
      $display("FAIL approx_cg_k2: cg_en_acc=%b, required 0", cg_en_acc);
    end
    if (!result_valid) wait_done();
    n_checks++;
    if (result_valid !== 1'b1 || result !== 16'd17) begin
      n_fail++;
      $display("FAIL approx_final: result=%0d valid=%b, required 17 1", result, result_valid);
    end
    release_result();
  endtask

  task automatic test_hold();
    int bad;
    do_accept(8'd100, 8'd50, 1'b0);
    wait_done();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = i[0];
      a = 8'd1 + 8'(i);
      b = 8'd2;
      approx_mode = 1'b0;
      #1;
      if (result_valid !== 1'b1 || result !== 16'd5000 || start_ready !== 1'b0 ||
          cg_en_op !== 1'b0 || cg_en_acc !== 1'b0) bad++;
    end
    @(negedge clk);
    start_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d bad cycles (result=%0d valid=%b ready=%b), required 0", bad, result, result_valid, start_ready);
    end
    release_result();
    n_checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: busy=%b start_ready=%b valid=%b, required 0 1 0", busy, start_ready, result_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_accept: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int exp_lat;
`ifdef ZERO_SKIP_EN
    exp_lat = 3;
`else
    exp_lat = 8;
`endif
    do_accept(8'd9, 8'd15, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 ||
        result !== 16'd0 || cg_en_acc !== 1'b0 || cg_en_op !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b busy=%b valid=%b result=%0d cga=%b cgo=%b, required 1 0 0 0 0 0",
               start_ready, busy, result_valid, result, cg_en_acc, cg_en_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_accept(8'd7, 8'd6, 1'b0);
    wait_done();
    n_checks++;
    if (result !== 16'd42 || lat !== exp_lat) begin
      n_fail++;
      $display("FAIL after_reset_7x6: result=%0d lat=%0d, required 42 %0d", result, lat, exp_lat);
    end
    release_result();
  endtask

  task automatic test_zero_skip();
    int exp_lat;
`ifdef ZERO_SKIP_EN
    exp_lat = 1;
`else
    exp_lat = 8;
`endif
    do_accept(8'd200, 8'd1, 1'b0);
    wait_done();
    n_checks++;
    if (result !== 16'd200 || lat !== exp_lat) begin
      n_fail++;
      $display("FAIL skip_200x1: result=%0d lat=%0d, required 200 %0d", result, lat, exp_lat);
    end
    release_result();
    do_accept(8'd77, 8'd0, 1'b1);
    wait_done();
`ifdef ZERO_SKIP_EN
    exp_lat = 1;
`else
    exp_lat = 8;
`endif
    n_checks++;
    if (result !== 16'd0 || lat !== exp_lat) begin
      n_fail++;
      $display("FAIL skip_b0: result=%0d lat=%0d, required 0 %0d", result, lat, exp_lat);
    end
    release_result();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_exact_basic();
    test_exact_max();
    test_approx();
    test_hold();
    test_reset_mid();
    test_zero_skip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
